cva6_icache_miss_hart_arbiter: RTL and testbench
================================================

Name: cva6_icache_miss_hart_arbiter

Overview:
- Sits directly upstream of the multicore cache arbitration/dispatch logic, between the per-hart I$ miss interfaces and the single shared I$ miss port.
- Selects one hart at a time by round-robin and registers that hart's miss request.
- Holds the grant until the matching fill acknowledge returns, then routes the acknowledge back to the owning hart only.
- Broadcasts invalidation returns to all harts and publishes the currently serviced hart index for the downstream dispatcher.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; supplies ICACHE_INV_REQ/ICACHE_IFILL_ACK encodings via the return type.
- icache_req_t, logic, I$ miss request type.
- icache_rtrn_t, logic, I$ return type; has field rtype.
- NrHarts, 1, number of harts sharing the port (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- hart_miss_valid_i  in  NrHarts  per-hart miss request valid
- hart_miss_ready_o  out  NrHarts  per-hart accept, at most one bit set
- hart_miss_i  in  NrHarts x $bits(icache_req_t)  per-hart request payload
- hart_rtrn_valid_o  out  NrHarts  per-hart return valid
- hart_rtrn_o  out  NrHarts x $bits(icache_rtrn_t)  per-hart return payload
- mem_miss_valid_o  out  1  shared-port request valid
- mem_miss_ready_i  in  1  shared-port accept
- mem_miss_o  out  $bits(icache_req_t)  registered request payload
- mem_rtrn_valid_i  in  1  shared-port return valid
- mem_rtrn_i  in  $bits(icache_rtrn_t)  return payload
- serviced_hart_o  out  HartIdxW  owner of current/last grant
- busy_o  out  1  FSM not in IDLE
- err_spurious_ack_o  out  1  one-cycle pulse on an unexpected IFILL_ACK

Behaviour:
Width and reset:
- HartIdxW = max(1, $clog2(NrHarts)).
- Reset values: state IDLE, rr_q = NrHarts-1 (hart 0 wins first), req_q = '0, owner_q = 0.
- All outputs are 0 during reset.

FSM states: IDLE, SEND, WAIT_ACK.
- IDLE: pick the first requesting hart scanning rr_q+1, rr_q+2, ... modulo NrHarts. If any hart is valid:
  - hart_miss_ready_o[pick] = 1 combinationally in the same cycle (ready depends on valid; acceptable on this boundary).
  - Capture req_q <= hart_miss_i[pick], owner_q <= pick, rr_q <= pick; go to SEND.
  - If no hart is valid, stay in IDLE.
- SEND:
  - mem_miss_valid_o = 1 and mem_miss_o = req_q, held stable until mem_miss_ready_i.
  - On the handshake, go to WAIT_ACK. The handshake and the ack may not be in the same cycle.
- WAIT_ACK: when mem_rtrn_valid_i is set and rtype == ICACHE_IFILL_ACK:
  - hart_rtrn_valid_o[owner_q] = 1 and hart_rtrn_o[owner_q] = mem_rtrn_i, same cycle (zero latency).
  - Go to IDLE. The next acceptance happens at the earliest on the following cycle.
- hart_miss_ready_o is 0 in SEND and WAIT_ACK.

Latencies and fairness:
- Request: hart accept at cycle N; mem_miss_valid_o from N+1.
- Minimum turnaround per miss is 3 cycles: accept, send, ack.
- Fairness: a continuously requesting hart waits at most NrHarts-1 grants.

Return routing:
- Invalidation (mem_rtrn_valid_i, rtype == ICACHE_INV_REQ) in any state: hart_rtrn_valid_o = all ones, hart_rtrn_o[*] = mem_rtrn_i. The FSM state is unaffected.
- IFILL_ACK seen in IDLE or SEND: dropped; no hart_rtrn_valid_o; err_spurious_ack_o pulses for 1 cycle.
- Return payload lanes that are not valid are driven to '0.

Other outputs and edge cases:
- serviced_hart_o = owner_q. busy_o = (state != IDLE).
- NrHarts == 1: the arbiter degenerates to a register slice; rr_q is constant 0.
- Reset asserted mid-operation (SEND/WAIT_ACK): FSM returns to IDLE immediately. The outstanding miss is abandoned; the shared port is reset concurrently by the same rst_ni.
- A hart deasserting valid before acceptance is legal. After acceptance the payload is held in req_q, so hart inputs are don't-care.

Decomposition:
- In the shared package (cva6 cache package): HartIdxW function/localparam helper and the state enum type cache_arb_state_e {IDLE, SEND, WAIT_ACK}.
- One natural sub-module: cva6_hart_rr_picker (combinational priority search from rr_q+1, outputs pick index and any_valid). rr_q register stays in the parent.

Test Plan:
1. NrHarts=4, hart 2 alone requests with vaddr 0x8000_0040, mem_miss_ready_i=1 -> ready_o=4'b0100 at cycle 0; mem_miss_valid_o at cycle 1 with the same payload; ack at cycle 3 -> hart_rtrn_valid_o=4'b0100 only; busy_o low at cycle 4.
2. All 4 harts request continuously, acks returned 2 cycles after send -> grant order 0,1,2,3,0; serviced_hart_o matches each grant.
3. mem_miss_ready_i held low 5 cycles in SEND -> mem_miss_valid_o and mem_miss_o stable all 5 cycles; no new hart accepted.
4. INV_REQ arrives during WAIT_ACK for hart 1 -> hart_rtrn_valid_o=4'b1111 that cycle; state stays WAIT_ACK; the later IFILL_ACK goes only to hart 1.
5. IFILL_ACK injected while IDLE -> err_spurious_ack_o=1 for exactly 1 cycle; hart_rtrn_valid_o=0.
6. rst_ni dropped in WAIT_ACK, released after 3 cycles, hart 3 requesting -> all outputs 0 during reset; first grant after release goes to hart 3 (rr_q reset to 3, scan starts at 0, first valid is 3).

Source files
------------

// File: rtl/cva6_icache_miss_hart_arbiter_pkg.sv
// Shared types and helpers for the I$ miss hart arbiter.
// Provides the return-type encodings, the core configuration struct, the
// default request/return payload types, the arbiter state enum and a helper for the hart index width.
package cva6_icache_miss_hart_arbiter_pkg;

  // Return-type encodings carried in the rtype field of an I$ return.
  localparam logic [1:0] ICACHE_INV_REQ   = 2'd0;
  localparam logic [1:0] ICACHE_IFILL_ACK = 2'd1;

  // Core configuration subset needed here: which rtype values mean what.
  typedef struct packed {
    logic [1:0] InvReqType;
    logic [1:0] IfillAckType;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    InvReqType:   ICACHE_INV_REQ,
    IfillAckType: ICACHE_IFILL_ACK
  };

  // Default miss request payload.
  typedef struct packed {
    logic [31:0] vaddr;
    logic        nc;
  } icache_miss_req_t;

  // Default return payload; rtype selects invalidation vs fill acknowledge.
  typedef struct packed {
    logic [1:0]  rtype;
    logic [31:0] data;
  } icache_miss_rtrn_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } cache_arb_state_e;

  // Hart index width; a single hart still needs a 1-bit index.
  function automatic int unsigned hart_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cva6_hart_rr_picker.sv
// Round-robin priority search over per-hart miss valids, starting after the last winner.
// Latency: purely combinational. Backpressure: none, the parent decides when the pick is used.
// Ports: i_valid (per-hart valid), i_rr (last winner), o_pick (chosen hart), o_any (some hart valid).
module cva6_hart_rr_picker
  import cva6_icache_miss_hart_arbiter_pkg::*;
#(
  parameter int unsigned NrHarts  = 1,
  parameter int unsigned HartIdxW = hart_idx_w(NrHarts)
) (
  input  logic [NrHarts-1:0]  i_valid,
  input  logic [HartIdxW-1:0] i_rr,
  output logic [HartIdxW-1:0] o_pick,
  output logic                o_any
);

  int unsigned w_dist;
  int unsigned w_best;

  // Each valid hart is ranked by its distance from rr+1 (mod NrHarts);
  // the smallest distance wins, which is the first hart met by the scan.
  always_comb begin
    o_pick = '0;
    o_any  = 1'b0;
    w_dist = 0;
    w_best = NrHarts;
    for (int unsigned j = 0; j < NrHarts; j++) begin
      w_dist = (j + 2 * NrHarts - 1 - 32'(i_rr)) % NrHarts;
      if ((((i_valid >> j) & NrHarts'(1)) != '0) && (w_dist < w_best)) begin
        w_best = w_dist;
        o_pick = HartIdxW'(j);
        o_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cva6_icache_miss_hart_arbiter.sv
// Round-robin arbiter of per-hart I$ misses onto one shared miss port, one miss in flight.
// Latency: accept at N, shared-port request from N+1, fill ack routed back combinationally.
// Backpressure: grant held until shared-port accept and fill ack; harts see ready only in IDLE.
// Ports: hart_miss_* (per-hart requests), hart_rtrn_* (per-hart returns), mem_miss_* / mem_rtrn_*
// (shared port), serviced_hart_o (current owner), busy_o, err_spurious_ack_o.
module cva6_icache_miss_hart_arbiter
  import cva6_icache_miss_hart_arbiter_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
  parameter type         icache_req_t  = icache_miss_req_t,
  parameter type         icache_rtrn_t = icache_miss_rtrn_t,
  parameter int unsigned NrHarts       = 1,
  parameter int unsigned HartIdxW      = hart_idx_w(NrHarts)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NrHarts-1:0]         hart_miss_valid_i,
  output logic [NrHarts-1:0]         hart_miss_ready_o,
  input  icache_req_t [NrHarts-1:0]  hart_miss_i,
  output logic [NrHarts-1:0]         hart_rtrn_valid_o,
  output icache_rtrn_t [NrHarts-1:0] hart_rtrn_o,
  output logic                       mem_miss_valid_o,
  input  logic                       mem_miss_ready_i,
  output icache_req_t                mem_miss_o,
  input  logic                       mem_rtrn_valid_i,
  input  icache_rtrn_t               mem_rtrn_i,
  output logic [HartIdxW-1:0]        serviced_hart_o,
  output logic                       busy_o,
  output logic                       err_spurious_ack_o
);

  cache_arb_state_e    r_state;
  cache_arb_state_e    w_state_nxt;
  logic [HartIdxW-1:0] r_rr;
  logic [HartIdxW-1:0] r_owner;
  icache_req_t         r_req;

  logic [HartIdxW-1:0] w_pick;
  logic                w_any;
  logic                w_accept;
  logic                w_is_inv;
  logic                w_is_ack;
  logic [NrHarts-1:0]  w_pick_onehot;
  logic [NrHarts-1:0]  w_owner_onehot;

  cva6_hart_rr_picker #(
    .NrHarts  (NrHarts),
    .HartIdxW (HartIdxW)
  ) u_picker (
    .i_valid (hart_miss_valid_i),
    .i_rr    (r_rr),
    .o_pick  (w_pick),
    .o_any   (w_any)
  );

  assign w_is_inv       = mem_rtrn_valid_i && (mem_rtrn_i.rtype == CVA6Cfg.InvReqType);
  assign w_is_ack       = mem_rtrn_valid_i && (mem_rtrn_i.rtype == CVA6Cfg.IfillAckType);
  assign w_accept       = (r_state == IDLE) && w_any;
  assign w_pick_onehot  = NrHarts'(1) << w_pick;
  assign w_owner_onehot = NrHarts'(1) << r_owner;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Invalidations never change state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_any) w_state_nxt = SEND;
      SEND:     if (mem_miss_ready_i) w_state_nxt = WAIT_ACK;
      WAIT_ACK: if (w_is_ack) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Output logic. Everything combinational is gated by rst_ni so the
  // block is silent while reset is held, even with harts requesting.
  always_comb begin
    hart_miss_ready_o  = '0;
    mem_miss_valid_o   = 1'b0;
    hart_rtrn_valid_o  = '0;
    err_spurious_ack_o = 1'b0;
    if (rst_ni) begin
      case (r_state)
        IDLE:     if (w_any) hart_miss_ready_o = w_pick_onehot;
        SEND:     mem_miss_valid_o = 1'b1;
        WAIT_ACK: ;
        default:  ;
      endcase
      if (w_is_inv) begin
        hart_rtrn_valid_o = '1;
      end else if (w_is_ack) begin
        if (r_state == WAIT_ACK) begin
          hart_rtrn_valid_o = w_owner_onehot;
        end else begin
          err_spurious_ack_o = 1'b1;
        end
      end
    end
  end

  // Request capture. rr starts at NrHarts-1 so hart 0 is scanned first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr    <= HartIdxW'(NrHarts - 1);
      r_owner <= '0;
      r_req   <= '0;
    end else if (w_accept) begin
      r_rr    <= w_pick;
      r_owner <= w_pick;
      r_req   <= hart_miss_i[w_pick];
    end
  end

  // Lanes that are not valid carry zero so stale data never leaks to a hart.
  for (genvar g = 0; g < NrHarts; g++) begin : g_lane
    assign hart_rtrn_o[g] = hart_rtrn_valid_o[g] ? mem_rtrn_i : '0;
  end

  assign mem_miss_o      = r_req;
  assign serviced_hart_o = r_owner;
  assign busy_o          = (r_state != IDLE);

endmodule

// File: tb/tb_cva6_icache_miss_hart_arbiter.sv
module tb_cva6_icache_miss_hart_arbiter;
  import cva6_icache_miss_hart_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           rst_n;
  logic [N-1:0]                   hart_vld;
  logic [N-1:0]                   hart_rdy;
  icache_miss_req_t [N-1:0]       hart_miss;
  logic [N-1:0]                   hart_rtrn_vld;
  icache_miss_rtrn_t [N-1:0]      hart_rtrn;
  logic                           mem_vld;
  logic                           mem_rdy;
  icache_miss_req_t               mem_miss;
  logic                           mem_rtrn_vld;
  icache_miss_rtrn_t              mem_rtrn;
  logic [1:0]                     serviced;
  logic                           busy;
  logic                           err_ack;

  cva6_icache_miss_hart_arbiter #(.NrHarts(N)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .hart_miss_valid_i  (hart_vld),
    .hart_miss_ready_o  (hart_rdy),
    .hart_miss_i        (hart_miss),
    .hart_rtrn_valid_o  (hart_rtrn_vld),
    .hart_rtrn_o        (hart_rtrn),
    .mem_miss_valid_o   (mem_vld),
    .mem_miss_ready_i   (mem_rdy),
    .mem_miss_o         (mem_miss),
    .mem_rtrn_valid_i   (mem_rtrn_vld),
    .mem_rtrn_i         (mem_rtrn),
    .serviced_hart_o    (serviced),
    .busy_o             (busy),
    .err_spurious_ack_o (err_ack)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction described by its phase
  // (0 none, 1 waiting for shared-port accept, 2 waiting for the fill ack).
  int               m_phase = 0;
  int               m_last  = N - 1;
  int               m_owner = 0;
  icache_miss_req_t m_req   = '0;
  int               obs_grants[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick();
    int h;
    for (int k = 1; k <= N; k++) begin
      h = (m_last + k) % N;
      if (hart_vld[h[1:0]]) return h;
    end
    return -1;
  endfunction

  // Check all outputs against the model for the current cycle, advance the
  // model as of the coming clock edge, then wait for the next drive point.
  task automatic tick();
    int           p;
    logic         inv;
    logic         ack;
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_rv;
    #1;
    if (!rst_n) begin
      m_phase = 0; m_last = N - 1; m_owner = 0; m_req = '0;
    end
    p     = model_pick();
    inv   = mem_rtrn_vld && (mem_rtrn.rtype == ICACHE_INV_REQ);
    ack   = mem_rtrn_vld && (mem_rtrn.rtype == ICACHE_IFILL_ACK);
    e_rdy = '0;
    e_rv  = '0;
    if (rst_n) begin
      if (m_phase == 0 && p >= 0) e_rdy[p[1:0]] = 1'b1;
      if (inv) e_rv = '1;
      else if (ack && m_phase == 2) e_rv[m_owner[1:0]] = 1'b1;
    end
    for (int i = 0; i < N; i++) if (hart_rdy[i[1:0]]) obs_grants.push_back(i);
    chk("miss_rdy", 64'(hart_rdy), 64'(e_rdy));
    chk("mem_vld", 64'(mem_vld), 64'(rst_n && m_phase == 1));
    chk("mem_dat", 64'(mem_miss), 64'(m_req));
    chk("rtrn_vld", 64'(hart_rtrn_vld), 64'(e_rv));
    for (int i = 0; i < N; i++)
      chk("rtrn_lane", 64'(hart_rtrn[i[1:0]]), e_rv[i[1:0]] ? 64'(mem_rtrn) : 64'(0));
    chk("err_ack", 64'(err_ack), 64'(rst_n && ack && m_phase != 2));
    chk("serviced", 64'(serviced), 64'(m_owner));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    if (rst_n) begin
      if (m_phase == 0) begin
        if (p >= 0) begin
          m_req = hart_miss[p[1:0]]; m_owner = p; m_last = p; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (mem_rdy) m_phase = 2;
      end else if (ack) begin
        m_phase = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    hart_vld = '0; mem_rdy = 1'b0; mem_rtrn_vld = 1'b0; mem_rtrn = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_ack(input logic [1:0] rtype);
    mem_rtrn_vld = 1'b1;
    mem_rtrn.rtype = rtype;
    mem_rtrn.data = $urandom();
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int wcnt;
  icache_miss_req_t held;

  initial begin
    rst_n = 1'b0;
    hart_miss = '0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Single hart, vaddr 0x8000_0040.
    hart_vld = 4'b0100; mem_rdy = 1'b1;
    hart_miss[2].vaddr = 32'h8000_0040; hart_miss[2].nc = 1'b0;
    #1 chk("t1_rdy", 64'(hart_rdy), 64'h4);
    tick();
    hart_vld = '0;
    #1 chk("t1_mem_vld", 64'(mem_vld), 64'h1);
    chk("t1_mem_addr", 64'(mem_miss.vaddr), 64'h8000_0040);
    tick();
    tick();
    set_ack(ICACHE_IFILL_ACK);
    #1 chk("t1_rtrn_vld", 64'(hart_rtrn_vld), 64'h4);
    tick();
    mem_rtrn_vld = 1'b0;
    #1 chk("t1_busy", 64'(busy), 64'h0);
    tick();

    // All harts requesting continuously, ack two cycles after send.
    do_reset();
    obs_grants.delete();
    hart_vld = '1; mem_rdy = 1'b1; wcnt = 0;
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < N; i++) hart_miss[i[1:0]] = '{vaddr: $urandom(), nc: 1'b0};
      if (m_phase == 2 && wcnt == 1) set_ack(ICACHE_IFILL_ACK);
      else mem_rtrn_vld = 1'b0;
      tick();
      wcnt = (m_phase == 2) ? wcnt + 1 : 0;
    end
    chk("t2_ngrants", 64'(obs_grants.size() >= 5), 64'h1);
    for (int i = 0; i < 5 && i < obs_grants.size(); i++)
      chk("t2_order", 64'(obs_grants[i]), 64'(exp_order[i]));

    // Shared port stalls five cycles in SEND.
    do_reset();
    hart_vld = '1; mem_rdy = 1'b0;
    hart_miss[0] = '{vaddr: 32'h1234_5678, nc: 1'b1};
    tick();
    held = hart_miss[0];
    for (int c = 0; c < 5; c++) begin
      #1 chk("t3_vld", 64'(mem_vld), 64'h1);
      chk("t3_dat", 64'(mem_miss), 64'(held));
      chk("t3_rdy", 64'(hart_rdy), 64'h0);
      tick();
    end
    mem_rdy = 1'b1;
    tick();
    set_ack(ICACHE_IFILL_ACK);
    tick();
    idle_inputs();
    tick();

    // Invalidation during WAIT_ACK for hart 1.
    do_reset();
    hart_vld = 4'b0010; mem_rdy = 1'b1;
    tick();
    hart_vld = '0;
    tick();
    set_ack(ICACHE_INV_REQ);
    #1 chk("t4_inv_vld", 64'(hart_rtrn_vld), 64'hf);
    chk("t4_busy", 64'(busy), 64'h1);
    tick();
    mem_rtrn_vld = 1'b0;
    tick();
    set_ack(ICACHE_IFILL_ACK);
    #1 chk("t4_ack_vld", 64'(hart_rtrn_vld), 64'h2);
    tick();

    // Spurious fill ack while idle.
    set_ack(ICACHE_IFILL_ACK);
    #1 chk("t5_err", 64'(err_ack), 64'h1);
    chk("t5_rv", 64'(hart_rtrn_vld), 64'h0);
    tick();
    mem_rtrn_vld = 1'b0;
    #1 chk("t5_err_clr", 64'(err_ack), 64'h0);
    tick();

    // Reset while waiting for the ack, hart 3 requesting throughout.
    do_reset();
    hart_vld = 4'b1000; mem_rdy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t6_rst_rdy", 64'(hart_rdy), 64'h0);
      chk("t6_rst_busy", 64'(busy), 64'h0);
      chk("t6_rst_mvld", 64'(mem_vld), 64'h0);
      tick();
    end
    rst_n = 1'b1;
    #1 chk("t6_first", 64'(hart_rdy), 64'h8);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      hart_vld = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        hart_miss[i[1:0]] = '{vaddr: $urandom(), nc: 1'($urandom_range(0, 1))};
      mem_rdy = 1'($urandom_range(0, 1));
      mem_rtrn_vld = ($urandom_range(0, 2) == 0);
      mem_rtrn.data = $urandom();
      case ($urandom_range(0, 9))
        0, 1:    mem_rtrn.rtype = ICACHE_INV_REQ;
        9:       mem_rtrn.rtype = 2'd2;
        default: mem_rtrn.rtype = ICACHE_IFILL_ACK;
      endcase
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
